// File: rtl/step_pulse_gen.sv
// step_pulse_gen: 50 % duty step-pulse generator for the activity tracker.
// Each pulse is one step. The rate is walk, jog or run, or a timed hybrid
// schedule. The block also keeps a saturating step count and a saturating
// elapsed-seconds count.
//
// Optional feature macro: STEP_PULSE_HYBRID_EN
//   defined   : mode 11 runs the hybrid walk/jog/run/jog segment schedule.
//   undefined : no segment logic; mode 11 runs as walk and cur_rate reads 00.
//
// Ports:
//   clk        : sole clock, posedge
//   rst_n      : asynchronous active-low reset
//   start      : level run request (low stops at the next edge)
//   mode       : 00 walk, 01 jog, 10 run, 11 hybrid (latched at start)
//   pulse      : step waveform
//   active     : high while running
//   cur_rate   : rate of the current period (00/01/10)
//   step_count : rising pulse edges since start, saturating
//   sec_count  : whole seconds since start, saturating
module step_pulse_gen #(
  parameter int unsigned CNT_W      = 22,
  parameter int unsigned WALK_HALF  = 1562500,
  parameter int unsigned JOG_HALF   = 781250,
  parameter int unsigned RUN_HALF   = 390625,
  parameter int unsigned SEC_CYCLES = 3125000,
  parameter int unsigned HYB_SEG_S  = 60,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  output logic               pulse,
  output logic               active,
  output logic [1:0]         cur_rate,
  output logic [COUNT_W-1:0] step_count,
  output logic [COUNT_W-1:0] sec_count
);

  localparam int unsigned SEC_W = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;

  localparam logic [CNT_W-1:0]   WALK_M1 = CNT_W'(WALK_HALF - 1);
  localparam logic [CNT_W-1:0]   JOG_M1  = CNT_W'(JOG_HALF - 1);
  localparam logic [CNT_W-1:0]   RUN_M1  = CNT_W'(RUN_HALF - 1);
  localparam logic [SEC_W-1:0]   SEC_M1  = SEC_W'(SEC_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  // Elaboration-time guard against an illegal parameter set.
  if (WALK_HALF == 0 || JOG_HALF == 0 || RUN_HALF == 0 ||
      SEC_CYCLES == 0 || HYB_SEG_S == 0) begin : g_bad_cfg
    $error("step_pulse_gen: illegal configuration");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [1:0]         rate_q, rate_d;
  logic [CNT_W-1:0]   half_cnt_q, half_cnt_d;
  logic [SEC_W-1:0]   sec_div_q, sec_div_d;
  logic [COUNT_W-1:0] sec_count_q, sec_count_d;
  logic [COUNT_W-1:0] step_count_q, step_count_d;
  logic               pulse_q, pulse_d;
  logic               active_q, active_d;

  logic               launch_c;
  logic               running_c;
  logic               sec_wrap_c;
  logic [CNT_W-1:0]   half_m1_c;
  logic [1:0]         reload_rate_c;

  assign launch_c   = start && (state_q == S_IDLE);
  assign running_c  = start && ((state_q == S_HIGH) || (state_q == S_LOW));
  assign sec_wrap_c = (sec_div_q == SEC_M1);

  // Terminal count of the half-period counter for the current period's rate.
  always_comb begin
    case (rate_q)
      2'b01:   half_m1_c = JOG_M1;
      2'b10:   half_m1_c = RUN_M1;
      default: half_m1_c = WALK_M1;
    endcase
  end

`ifdef STEP_PULSE_HYBRID_EN
  localparam int unsigned      SEG_W  = (HYB_SEG_S > 1) ? $clog2(HYB_SEG_S) : 1;
  localparam logic [SEG_W-1:0] SEG_M1 = SEG_W'(HYB_SEG_S - 1);

  logic [1:0]       seg_idx_q, seg_idx_d;
  logic [SEG_W-1:0] seg_sec_q, seg_sec_d;

  // Segment index advances on the second tick that completes a segment.
  always_comb begin
    seg_idx_d = seg_idx_q;
    seg_sec_d = seg_sec_q;
    if (launch_c) begin
      seg_idx_d = 2'd0;
      seg_sec_d = '0;
    end else if (running_c && sec_wrap_c) begin
      if (seg_sec_q == SEG_M1) begin
        seg_sec_d = '0;
        seg_idx_d = seg_idx_q + 2'd1;
      end else begin
        seg_sec_d = seg_sec_q + SEG_W'(1);
      end
    end
  end

  // Uses the next segment index so an advance on the LOW->HIGH edge applies
  // to the period that starts there.
  always_comb begin
    reload_rate_c = (mode_q == 2'b11) ? 2'b00 : mode_q;
    if (mode_q == 2'b11) begin
      case (seg_idx_d)
        2'd0:    reload_rate_c = 2'b00;
        2'd1:    reload_rate_c = 2'b01;
        2'd2:    reload_rate_c = 2'b10;
        default: reload_rate_c = 2'b01;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_idx_q <= 2'd0;
      seg_sec_q <= '0;
    end else begin
      seg_idx_q <= seg_idx_d;
      seg_sec_q <= seg_sec_d;
    end
  end
`else
  assign reload_rate_c = (mode_q == 2'b11) ? 2'b00 : mode_q;
`endif

  // Next-state and output logic; a low start overrides everything.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    rate_d       = rate_q;
    half_cnt_d   = half_cnt_q;
    sec_div_d    = sec_div_q;
    sec_count_d  = sec_count_q;
    step_count_d = step_count_q;
    pulse_d      = pulse_q;
    active_d     = active_q;
    if (!start) begin
      state_d  = S_IDLE;
      pulse_d  = 1'b0;
      active_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d      = S_HIGH;
          pulse_d      = 1'b1;
          active_d     = 1'b1;
          mode_d       = mode;
          // Hybrid segment 0 is walk, so hybrid also starts at rate 00.
          rate_d       = (mode == 2'b11) ? 2'b00 : mode;
          half_cnt_d   = '0;
          sec_div_d    = '0;
          sec_count_d  = '0;
          step_count_d = COUNT_W'(1);
        end
        S_HIGH, S_LOW: begin
          if (sec_wrap_c) begin
            sec_div_d = '0;
            if (sec_count_q != CNT_MAX) begin
              sec_count_d = sec_count_q + COUNT_W'(1);
            end
          end else begin
            sec_div_d = sec_div_q + SEC_W'(1);
          end
          if (half_cnt_q == half_m1_c) begin
            half_cnt_d = '0;
            if (state_q == S_HIGH) begin
              state_d = S_LOW;
              pulse_d = 1'b0;
            end else begin
              state_d = S_HIGH;
              pulse_d = 1'b1;
              rate_d  = reload_rate_c;
              if (step_count_q != CNT_MAX) begin
                step_count_d = step_count_q + COUNT_W'(1);
              end
            end
          end else begin
            half_cnt_d = half_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d  = S_IDLE;
          pulse_d  = 1'b0;
          active_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 2'b00;
      rate_q       <= 2'b00;
      half_cnt_q   <= '0;
      sec_div_q    <= '0;
      sec_count_q  <= '0;
      step_count_q <= '0;
      pulse_q      <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      rate_q       <= rate_d;
      half_cnt_q   <= half_cnt_d;
      sec_div_q    <= sec_div_d;
      sec_count_q  <= sec_count_d;
      step_count_q <= step_count_d;
      pulse_q      <= pulse_d;
      active_q     <= active_d;
    end
  end

  assign pulse      = pulse_q;
  assign active     = active_q;
  assign cur_rate   = rate_q;
  assign step_count = step_count_q;
  assign sec_count  = sec_count_q;

endmodule
